sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy flags and sticky
// overflow/underflow error flags. Storage is a circular buffer addressed by
// free-running read/write pointers that wrap modulo DEPTH.
module sync_fifo #(
  parameter int DEPTH        = 8,
  parameter int BITS         = 64,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [BITS-1:0]        d,
  input  logic                   pop,
  input  logic                   clr_err,
  output logic [BITS-1:0]        q,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [BITS-1:0] mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic            push_acc;
  logic            pop_acc;

  // Flags come only from registered occupancy, so push/pop never reach them
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AFULL_C);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign q           = empty ? '0 : mem_q[rd_ptr_q];

  // Acceptance: a full FIFO still takes a push when the head leaves in the
  // same cycle (full implies non-empty, so pop alone frees the slot)
  always_comb begin
    pop_acc  = pop && !empty;
    push_acc = push && (!full || pop_acc);
  end

  // Next-state for storage, pointers, occupancy and sticky error flags
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_acc) begin
      mem_d[wr_ptr_q] = d;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Setting an error wins over a coincident clear
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push && !push_acc) overflow_d  = 1'b1;
    if (pop && !pop_acc)   underflow_d = 1'b1;
  end

  // State registers with asynchronous clear of contents and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
